// File: rtl/sram_arb_pkg.sv
`default_nettype none
// =============================================================================
// sram_arb_pkg : shared defaults, state encoding and response tag for the
//                SRAM port-0 arbiter.                               Rev 1.0
// =============================================================================
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_WMASKS = 1;
  localparam int RAM_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/sram_rr_arb2.sv
`default_nettype none
// =============================================================================
// sram_rr_arb2 : two-way round-robin grant with a transfer-advanced pointer.
//                                                                   Rev 1.0
// =============================================================================
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // ptr = 1 means requester 1 wins the next contended cycle
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant always carries a valid request, so it marks a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port0_arbiter.sv
`default_nettype none
// =============================================================================
// sram_port0_arbiter : round-robin front end for SRAM macro port 0 with a
//                      pipelined read-response path.
// Option macro: SRAM_ARB_INIT_EN (zero-fill the macro after reset). Rev 1.0
// =============================================================================
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0,
  output logic                    init_done
);

  logic                  run;
  logic [1:0]            grant;
  logic                  xfer;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NUM_WMASKS-1:0] sel_wmask;

  logic                  cmd_load;
  logic                  cmd_web;
  logic [NUM_WMASKS-1:0] cmd_wmask;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_din;

  rsp_tag_t              tag_s1;
  rsp_tag_t              tag_s2;

`ifdef SRAM_ARB_INIT_EN
  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] init_addr;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else if (state == ST_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (&init_addr) begin
        state <= ST_RUN;
      end
    end
  end

  assign run       = (state == ST_RUN);
  assign init_done = run;
`else
  // No fill phase: requests are accepted as soon as reset is released.
  assign run       = rst0_n;
  assign init_done = 1'b1;
`endif

  sram_rr_arb2 u_rr_arb (
    .clk    (clk0),
    .rst_n  (rst0_n),
    .enable (run),
    .valid  (req_valid),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign win       = grant[1];
  assign sel_we    = req_we[win];
  assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_wmask = win ? req_wmask[2*NUM_WMASKS-1:NUM_WMASKS] : req_wmask[NUM_WMASKS-1:0];

  always_comb begin
    cmd_load  = xfer;
    cmd_web   = ~sel_we;
    cmd_wmask = sel_wmask;
    cmd_addr  = sel_addr;
    cmd_din   = sel_wdata;
`ifdef SRAM_ARB_INIT_EN
    if (state == ST_INIT) begin
      cmd_load  = 1'b1;
      cmd_web   = 1'b0;
      cmd_wmask = '1;
      cmd_addr  = init_addr;
      cmd_din   = '0;
    end
`endif
  end

  // Idle cycles only deselect the macro; the other pins keep their last value.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0 <= ~cmd_load;
      if (cmd_load) begin
        sram_web0   <= cmd_web;
        sram_wmask0 <= cmd_wmask;
        sram_addr0  <= cmd_addr;
        sram_din0   <= cmd_din;
      end
    end
  end

  // Macro samples the command one edge after it is registered and drives
  // dout before the following edge, hence two tag stages before capture.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      tag_s1    <= '0;
      tag_s2    <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      tag_s1.valid <= xfer & ~sel_we;
      tag_s1.id    <= win;
      tag_s2       <= tag_s1;
      rsp_valid    <= {tag_s2.valid & tag_s2.id, tag_s2.valid & ~tag_s2.id};
      if (tag_s2.valid) begin
        rsp_rdata <= sram_dout0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port0_arbiter.sv
`default_nettype none
// =============================================================================
// tb_sram_port0_arbiter : directed + random bench with a behavioural SRAM
//                         macro and a transaction-level reference model.
// Option macro: SRAM_ARB_INIT_EN (adds the fill-phase scenario).   Rev 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_sram_port0_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int NM    = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk0   = 1'b0;
  logic          rst0_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*NM-1:0] req_wmask = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;
  logic          init_done;

  sram_port0_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WMASKS (NM)
  ) dut (
    .clk0        (clk0),
    .rst0_n      (rst0_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0),
    .init_done   (init_done)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [DW-1:0] fill_val(input int i);
    return DW'((i * 29 + 7) % 256);
  endfunction

  // Behavioural macro: command sampled at the edge, read data valid after it.
  logic [DW-1:0] mac [DEPTH];
  bit            mac_filled = 1'b0;
  always @(posedge clk0) begin
    if (!mac_filled) begin
      for (int i = 0; i < DEPTH; i++) mac[i] = fill_val(i);
      mac_filled = 1'b1;
    end
    if (!sram_csb0) begin
      if (!sram_web0) begin
        if (sram_wmask0[0]) mac[sram_addr0] = sram_din0;
      end else begin
        sram_dout0 <= mac[sram_addr0];
      end
    end
  end

  // Reference model state
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          rq[$];
  int            ptr;
  int            cyc;
  bit            model_run;
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_ready;
  logic [5:0]    gseq;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [1:0] m);
    logic [1:0]    eg;
    logic [1:0]    erv;
    int            win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ecsb, eweb, emask;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    rsp_t          r;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_wmask = m;
    #1;
    eg = 2'b00;
    if (model_run) eg = (v == 2'b11) ? ((ptr == 0) ? 2'b01 : 2'b10) : v;
    last_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(eg));
    @(posedge clk0);
    cyc++;
    ecsb = 1'b1; eweb = 1'b1; emask = 1'b0; eaddr = '0; edin = '0;
    if (eg != 2'b00) begin
      win  = eg[1] ? 1 : 0;
      ptr  = 1 - win;
      gseq = {gseq[4:0], eg[1]};
      a    = win ? a1 : a0;
      d    = win ? d1 : d0;
      ecsb = 1'b0;
      eaddr = a;
      if (we[win]) begin
        eweb  = 1'b0;
        edin  = d;
        emask = m[win];
        if (m[win]) ref_mem[a] = d;
      end else begin
        r.due = cyc + 2; r.id = win; r.data = ref_mem[a];
        rq.push_back(r);
      end
    end
    @(negedge clk0);
    chk("sram_csb0", 64'(sram_csb0), 64'(ecsb));
    if (!ecsb) begin
      chk("sram_web0", 64'(sram_web0), 64'(eweb));
      chk("sram_addr0", 64'(sram_addr0), 64'(eaddr));
      if (!eweb) begin
        chk("sram_din0", 64'(sram_din0), 64'(edin));
        chk("sram_wmask0", 64'(sram_wmask0), 64'(emask));
      end
    end
    erv = 2'b00;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv = (rq[0].id == 1) ? 2'b10 : 2'b01;
      last_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rdata));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
  endtask

  task automatic do_reset(input int hold);
    int bad;
    rst0_n    = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    model_run = 1'b0;
    rq.delete();
    ptr        = 0;
    last_rdata = '0;
    #1;
    chk("rst_csb0", 64'(sram_csb0), 64'(1));
    chk("rst_web0", 64'(sram_web0), 64'(1));
    chk("rst_wmask0", 64'(sram_wmask0), 64'(0));
    chk("rst_addr0", 64'(sram_addr0), 64'(0));
    chk("rst_din0", 64'(sram_din0), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
`ifdef SRAM_ARB_INIT_EN
    chk("rst_init_done", 64'(init_done), 64'(0));
`else
    chk("rst_init_done", 64'(init_done), 64'(1));
`endif
    repeat (hold) @(negedge clk0);
    rst0_n = 1'b1;
`ifdef SRAM_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (req_ready !== 2'b00 || init_done !== 1'b0) bad++;
      @(negedge clk0);
    end
    chk("init_ready_low_cycles", 64'(bad), 64'(0));
    #1;
    chk("init_done_rise", 64'(init_done), 64'(1));
`else
    bad = 0;
`endif
    model_run = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_val(i);
    cyc = 0; gseq = '0; last_ready = '0;
    @(negedge clk0);
    do_reset(3);

    // both requesters reading for six cycles
    gseq = '0;
    for (int i = 0; i < 6; i++)
      drive_cycle(2'b11, 2'b00, AW'(10 + i), AW'(20 + i), '0, '0, 2'b00);
    chk("alt_grant_seq", 64'(gseq), 64'(6'b010101));
    idle(3);

    // write then immediate read of the top address
    drive_cycle(2'b01, 2'b01, AW'(10'h3FF), '0, 8'hA5, '0, 2'b01);
    drive_cycle(2'b01, 2'b00, AW'(10'h3FF), '0, '0, '0, 2'b00);
    idle(2);
    chk("wr_rd_3ff_valid", 64'(rsp_valid), 64'(2'b01));
    chk("wr_rd_3ff_data", 64'(rsp_rdata), 64'(8'hA5));
    idle(1);

    // a write with its mask cleared leaves the word untouched
    drive_cycle(2'b10, 2'b10, '0, AW'(5), '0, 8'h11, 2'b10);
    drive_cycle(2'b10, 2'b10, '0, AW'(5), '0, 8'hEE, 2'b00);
    drive_cycle(2'b10, 2'b00, '0, AW'(5), '0, '0, 2'b00);
    idle(2);
    chk("masked_wr_valid", 64'(rsp_valid), 64'(2'b10));
    chk("masked_wr_data", 64'(rsp_rdata), 64'(8'h11));
    idle(1);

    // pointer survives an idle stretch
    drive_cycle(2'b01, 2'b00, AW'(1), '0, '0, '0, 2'b00);
    idle(10);
    drive_cycle(2'b11, 2'b00, AW'(2), AW'(3), '0, '0, 2'b00);
    chk("ptr_after_idle", 64'(last_ready), 64'(2'b10));
    idle(3);

    for (int n = 0; n < 400; n++)
      drive_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)));
    idle(3);

    // reset right after a read is accepted
    drive_cycle(2'b10, 2'b00, '0, AW'(3), '0, '0, 2'b00);
    do_reset(2);
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
      if (rsp_valid !== 2'b00) nz++;
    end
    chk("no_rsp_after_reset", 64'(nz), 64'(0));

`ifdef SRAM_ARB_INIT_EN
    drive_cycle(2'b01, 2'b00, AW'(0), '0, '0, '0, 2'b00);
    drive_cycle(2'b01, 2'b00, AW'(DEPTH - 1), '0, '0, '0, 2'b00);
    drive_cycle(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    chk("init_rd0_valid", 64'(rsp_valid), 64'(2'b01));
    chk("init_rd0_data", 64'(rsp_rdata), 64'(0));
    drive_cycle(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    chk("init_rd_top_valid", 64'(rsp_valid), 64'(2'b01));
    chk("init_rd_top_data", 64'(rsp_rdata), 64'(0));
    idle(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_port0_arbiter.md
SRAM_PORT0_ARBITER -- requirements
Module: sram_port0_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SRAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 1, write-mask bits, one per 8 data bits.
REQ-004 SHALL have port clk0, input, 1, the only clock.
REQ-005 SHALL have port rst0_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester command valid.
REQ-007 SHALL have port req_ready, output, 2, per-requester command accept.
REQ-008 SHALL have port req_we, input, 2, 1 = write, 0 = read.
REQ-009 SHALL have ports req_addr / req_wdata / req_wmask, input, 2×ADDR_WIDTH / 2×DATA_WIDTH / 2×NUM_WMASKS, flattened; requester i occupies slice i.
REQ-010 SHALL have ports rsp_valid, output, 2, and rsp_rdata, output, DATA_WIDTH, read-response strobe and data.
REQ-011 SHALL have ports sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, output, 1/1/NUM_WMASKS/ADDR_WIDTH/DATA_WIDTH, driving macro port 0.
REQ-012 SHALL have port sram_dout0, input, DATA_WIDTH, macro port-0 read data.
REQ-013 SHALL have port init_done, output, 1, memory usable.

Function
REQ-014 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i] at a clk0 rising edge.
REQ-015 req_ready SHALL be one-hot or zero; it SHALL be zero unless the FSM is in RUN.
REQ-016 Single valid requester SHALL be granted; both valid SHALL be granted to the round-robin pointer, which then points to the other requester.
REQ-017 The pointer SHALL change only on a transfer.
REQ-018 On a transfer at edge E, sram_* SHALL be registered at E: csb0=0, web0=!we, and addr/din/wmask from the winner; with no transfer, sram_csb0 SHALL be registered 1.
REQ-019 Read accepted at edge E SHALL register sram_dout0 at E+2, with rsp_valid[i] high for exactly the one cycle after E+2 and rsp_rdata holding the data.
REQ-020 Writes SHALL produce no response.
REQ-021 One transfer per cycle SHALL be sustainable, with back-to-back reads pipelined, responses in acceptance order, and no response backpressure.
REQ-022 A read accepted one cycle after a write to the same address SHALL return the written data.
REQ-023 rsp_rdata SHALL hold its last value when rsp_valid is 0.

Reset
REQ-024 Reset SHALL set sram_csb0=1, sram_web0=1, and sram_wmask0, sram_addr0, sram_din0, rsp_valid, rsp_rdata and req_ready all to 0, with pointer on requester 0.
REQ-025 Reset asserted mid-operation SHALL discard in-flight reads; no rsp_valid SHALL follow reset release for them.
REQ-026 Release SHALL enter INIT if SRAM_ARB_INIT_EN is defined, else RUN.

Configuration
REQ-027 With SRAM_ARB_INIT_EN defined, FSM INIT SHALL write 0, full mask, to addresses 0..2^ADDR_WIDTH-1, one per cycle, with req_ready=0, then enter RUN and set init_done=1; init_done resets to 0.
REQ-028 Without SRAM_ARB_INIT_EN, INIT and its counter SHALL be absent and init_done SHALL be constant 1.
REQ-029 RUN SHALL be left only by reset.

Structure
REQ-030 Package sram_arb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults, the RAM_DEPTH constant and the FSM state enum (INIT, RUN).
REQ-031 Sub-module sram_rr_arb2 SHALL implement the 2-way round-robin grant and pointer (REQ-016/017).
REQ-032 Response tracking SHALL be a 2-stage {valid, id} shift pipeline in the top module.

Verification
REQ-033 Bench SHALL cover: requester 0 writes 0xA5 to addr 0x3FF, then reads 0x3FF the next cycle -> rsp_valid[0] 2 cycles after the read transfer, rsp_rdata=0xA5.
REQ-034 Bench SHALL cover: both requesters hold reads for 6 cycles -> grants alternate 0,1,0,1,0,1; six responses in order with correct ids.
REQ-035 Bench SHALL cover: write with wmask=0 to addr 5 holding 0x11 -> subsequent read returns 0x11.
REQ-036 Bench SHALL cover: reset asserted the cycle after a read transfer -> all outputs at reset values, no rsp_valid ever for that read.
REQ-037 Bench SHALL cover, with SRAM_ARB_INIT_EN: release reset -> req_ready=0 for 1024 cycles, init_done rises, and reads of addrs 0 and 1023 return 0x00.
REQ-038 Bench SHALL cover: no req_valid for 10 cycles -> sram_csb0=1 throughout and the pointer unchanged.
